// File: rtl/gf_pkg.sv
// Shared GF(Q) helpers: width derivations, modular reduction/inverse, and the
// enums used by the systemizer FSM and its word ALU.
package gf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Like clog2, but never returns a zero-width field.
  function automatic int width_of(input int n);
    int r;
    r = clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_ew(input int q);
    return width_of(q);
  endfunction

  function automatic int calc_w(input int k, input int block);
    return k / block;
  endfunction

  function automatic int calc_dw(input int block, input int q);
    return block * calc_ew(q);
  endfunction

  function automatic int calc_aw(input int l, input int k, input int block);
    return width_of(l * calc_w(k, block));
  endfunction

  function automatic int gf_mod(input int v, input int q);
    return v % q;
  endfunction

  // Returns 0 for a zero (or multiple of q) argument.
  function automatic int gf_inv(input int v, input int q);
    int r;
    r = 0;
    for (int x = 1; x < 8; x++)
      if (x < q && (((v % q) * x) % q) == 1) r = x;
    return r;
  endfunction

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SCALE,
    ALU_MSUB
  } alu_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_FIX,
    S_NORM,
    S_ELIM,
    S_FINISH
  } gfq_state_e;

endpackage

// File: rtl/gf_word_alu.sv
// BLOCK-lane combinational GF(Q) word ALU: add (a+b), scale (s*a) and
// multiply-subtract (a - s*b), every lane reduced into 0..Q-1.
module gf_word_alu
  import gf_pkg::*;
#(
  parameter int Q     = 3,
  parameter int BLOCK = 4,
  parameter int EW    = 2
) (
  input  alu_mode_e             mode,
  input  logic [EW-1:0]         scalar,
  input  logic [BLOCK*EW-1:0]   a,
  input  logic [BLOCK*EW-1:0]   b,
  output logic [BLOCK*EW-1:0]   y
);

  always_comb begin
    int av;
    int bv;
    int sv;
    int acc;
    y   = '0;
    av  = 0;
    bv  = 0;
    sv  = 0;
    acc = 0;
    for (int l = 0; l < BLOCK; l++) begin
      av = int'(a[l*EW +: EW]);
      bv = int'(b[l*EW +: EW]);
      sv = int'(scalar) % Q;
      case (mode)
        ALU_ADD:   acc = av + bv;
        ALU_SCALE: acc = sv * av;
        // Subtraction as addition of the additive inverse keeps acc non-negative.
        ALU_MSUB:  acc = av + (Q - sv) * bv;
        default:   acc = av;
      endcase
      y[l*EW +: EW] = EW'(acc % Q);
    end
  end

endmodule

// File: rtl/systemizer_gfq.sv
// Gauss-Jordan reduction of an L x K matrix over GF(Q) into systematic form
// [I | P], one memory word per cycle, with host read/write access while idle.
module systemizer_gfq
  import gf_pkg::*;
#(
  parameter int L     = 8,
  parameter int K     = 16,
  parameter int Q     = 3,
  parameter int BLOCK = 4,
  localparam int EW = calc_ew(Q),
  localparam int W  = calc_w(K, BLOCK),
  localparam int DW = calc_dw(BLOCK, Q),
  localparam int AW = calc_aw(L, K, BLOCK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          success,
  output logic          fail,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] data_out,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] data_in,
  output gfq_state_e    state_dbg
);

  localparam int N  = L * W;
  localparam int RW = width_of(L + 2);
  localparam int WW = width_of(W);
  localparam int LW = width_of(BLOCK);

  // Handshake: start is taken only when busy=0; busy stays high until the
  // cycle done pulses, and success/fail are valid from that pulse onward.
  logic [DW-1:0] mem [N];
  gfq_state_e    state;
  logic [RW-1:0] col, row, row_sel, next_row;
  logic [WW-1:0] col_word, wi;
  logic [LW-1:0] col_lane;
  logic [EW-1:0] scal, e_rc, e_cc, inv_cc, coef_now, alu_s;
  logic          ok, row_ok, next_ok, coef_zero, elim_row_end;
  logic [DW-1:0] row_data, col_data, alu_a, alu_b, alu_y;
  logic [AW-1:0] row_addr, col_addr, fsm_addr;
  logic          fsm_we, host_we;
  alu_mode_e     alu_mode;

  function automatic logic [EW-1:0] lane_of(input logic [DW-1:0] w, input logic [LW-1:0] ln);
    logic [EW-1:0] r;
    r = '0;
    for (int l = 0; l < BLOCK; l++)
      if (LW'(l) == ln) r = w[l*EW +: EW];
    return r;
  endfunction

  assign state_dbg = state;

  always_comb begin
    row_ok   = (row < RW'(L));
    row_sel  = row_ok ? row : '0;
    next_row = row + RW'(1);
    if (next_row == col) next_row = next_row + RW'(1);
    next_ok  = row_ok && (next_row < RW'(L));

    row_addr = AW'(int'(row_sel) * W + int'(wi));
    col_addr = AW'(int'(col) * W + int'(wi));
    row_data = mem[row_addr];
    col_data = mem[col_addr];
    e_rc     = lane_of(mem[AW'(int'(row_sel) * W + int'(col_word))], col_lane);
    e_cc     = lane_of(mem[AW'(int'(col) * W + int'(col_word))], col_lane);
    inv_cc   = EW'(gf_inv(int'(e_cc), Q));
    coef_now = EW'(gf_mod(int'(e_rc), Q));
    coef_zero = (coef_now == '0);
    elim_row_end = !row_ok || (wi == '0 && coef_zero) || (wi == WW'(W - 1));

    fsm_we   = 1'b0;
    fsm_addr = row_addr;
    alu_mode = ALU_ADD;
    alu_a    = col_data;
    alu_b    = row_data;
    alu_s    = EW'(1);
    case (state)
      S_FIX: begin
        fsm_we   = 1'b1;
        fsm_addr = col_addr;
      end
      // Word 0 uses the live pivot/coefficient; later words use the copy
      // latched on word 0, since word 0 may hold the pivot column itself.
      S_NORM: begin
        fsm_we   = 1'b1;
        fsm_addr = col_addr;
        alu_mode = ALU_SCALE;
        alu_s    = (wi == '0) ? inv_cc : scal;
      end
      S_ELIM: begin
        fsm_we   = row_ok && !(wi == '0 && coef_zero);
        fsm_addr = row_addr;
        alu_mode = ALU_MSUB;
        alu_a    = row_data;
        alu_b    = col_data;
        alu_s    = (wi == '0) ? coef_now : scal;
      end
      default: ;
    endcase
  end

  assign host_we = wr_en && (state == S_IDLE) && !start && (int'(wr_addr) < N);

  gf_word_alu #(
    .Q     (Q),
    .BLOCK (BLOCK),
    .EW    (EW)
  ) u_alu (
    .mode   (alu_mode),
    .scalar (alu_s),
    .a      (alu_a),
    .b      (alu_b),
    .y      (alu_y)
  );

  // The array is deliberately outside reset so a host can inspect it afterwards.
  always_ff @(posedge clk) begin
    if (fsm_we && !rst) mem[fsm_addr] <= alu_y;
    else if (host_we)   mem[wr_addr]  <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst)                                       data_out <= '0;
    else if (rd_en && !busy && int'(rd_addr) < N)  data_out <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      success  <= 1'b0;
      fail     <= 1'b0;
      ok       <= 1'b0;
      col      <= '0;
      col_word <= '0;
      col_lane <= '0;
      row      <= '0;
      wi       <= '0;
      scal     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SEARCH;
            busy     <= 1'b1;
            success  <= 1'b0;
            fail     <= 1'b0;
            ok       <= 1'b0;
            col      <= '0;
            col_word <= '0;
            col_lane <= '0;
            row      <= '0;
            wi       <= '0;
          end
        end
        S_SEARCH: begin
          if (!coef_zero) begin
            wi    <= '0;
            state <= (row == col) ? S_NORM : S_FIX;
          end else if (row >= RW'(L - 1)) begin
            ok    <= 1'b0;
            state <= S_FINISH;
          end else begin
            row <= row + RW'(1);
          end
        end
        S_FIX: begin
          if (wi == WW'(W - 1)) begin
            wi    <= '0;
            state <= S_NORM;
          end else begin
            wi <= wi + WW'(1);
          end
        end
        S_NORM: begin
          if (wi == '0) scal <= inv_cc;
          if (wi == WW'(W - 1)) begin
            wi    <= '0;
            row   <= (col == '0) ? RW'(1) : '0;
            state <= S_ELIM;
          end else begin
            wi <= wi + WW'(1);
          end
        end
        S_ELIM: begin
          if (fsm_we) begin
            if (wi == '0) scal <= coef_now;
            wi <= (wi == WW'(W - 1)) ? '0 : wi + WW'(1);
          end
          if (elim_row_end) begin
            if (next_ok) begin
              row <= next_row;
            end else if (col == RW'(L - 1)) begin
              ok    <= 1'b1;
              state <= S_FINISH;
            end else begin
              col   <= col + RW'(1);
              row   <= col + RW'(1);
              state <= S_SEARCH;
              if (col_lane == LW'(BLOCK - 1)) begin
                col_lane <= '0;
                col_word <= col_word + WW'(1);
              end else begin
                col_lane <= col_lane + LW'(1);
              end
            end
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          success <= ok;
          fail    <= !ok;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/systemizer_gfq.md
SYSTEMIZER_GFQ -- requirements
Module: systemizer_gfq

Interface
REQ-001 SHALL have parameter L, default 8, number of matrix rows (pivot columns 0..L-1).
REQ-002 SHALL have parameter K, default 16, number of matrix columns, with L <= K and K % BLOCK == 0.
REQ-003 SHALL have parameter Q, default 3, prime field modulus in 2..7; element width EW = CLOG2(Q).
REQ-004 SHALL have parameter BLOCK, default 4, elements per memory word; W = K/BLOCK words per row, DW = BLOCK*EW, AW = CLOG2(L*W).
REQ-005 SHALL have ports: clk input 1, rising-edge clock; the design uses one clock.
REQ-006 SHALL have port rst input 1; reset is synchronous and active-high.
REQ-007 SHALL have ports: start input 1 (begin reduction); busy output 1; done output 1 (one-cycle pulse); success output 1; fail output 1.
REQ-008 SHALL have ports: rd_en input 1; rd_addr input AW; data_out output DW (host read).
REQ-009 SHALL have ports: wr_en input 1; wr_addr input AW; data_in input DW (host write).

Function
REQ-010 SHALL store element (r,j) in word r*W + j/BLOCK, lane j%BLOCK, bits [lane*EW +: EW], in an internal L*W x DW flop array.
REQ-011 SHALL perform host writes only while busy=0; writes while busy=1 are dropped.
REQ-012 SHALL register data_out one cycle after rd_en while busy=0; data_out holds its value otherwise.
REQ-013 SHALL accept start only in IDLE; start with wr_en in the same cycle: start wins, write dropped; start while busy ignored.
REQ-014 SHALL use states IDLE, SEARCH, FIX, NORM, ELIM, FINISH; busy=1 in every state except IDLE.
REQ-015 SEARCH: for pivot column c, SHALL test one row per cycle from r=c upward; first r with a(r,c)!=0 ends search; none found -> FINISH with fail.
REQ-016 FIX: if r!=c, SHALL add row r into row c mod Q over W cycles (one word per cycle); skipped when r==c.
REQ-017 NORM: SHALL multiply row c by inv(a(c,c)) mod Q over W cycles, pivot value latched at entry.
REQ-018 ELIM: for each row i!=c in ascending order, SHALL latch coefficient a(i,c); nonzero -> row_i -= coef*row_c mod Q over W cycles; zero -> skip in 1 cycle.
REQ-019 After ELIM of c=L-1 SHALL enter FINISH with success; otherwise c increments, go to SEARCH.
REQ-020 FINISH SHALL last one cycle with done=1, then IDLE; success/fail hold until next accepted start, which clears both.
REQ-021 All arithmetic SHALL be exact mod Q; lane results always in 0..Q-1; inputs >= Q are undefined but must not hang the FSM.

Reset
REQ-022 rst SHALL force IDLE, c=0, busy=0, done=0, success=0, fail=0, data_out=0, including mid-operation.
REQ-023 rst SHALL NOT clear the matrix array; contents after mid-operation reset are partially reduced but well-defined values.

Structure
REQ-024 EW, W, DW, AW derivations and the mod-Q inverse table/function SHALL live in a shared package/header (gf_pkg), alongside existing CLOG2.
REQ-025 SHALL instantiate one sub-module gf_word_alu: BLOCK-lane combinational a + s*b mod Q (mode add, scale, multiply-subtract).

Verification (L=2, K=4, Q=3, BLOCK=2; rows listed as elements)
REQ-026 Load [[1,0,2,1],[0,1,1,1]], start -> done exactly 9 cycles after start sampled, success=1, matrix unchanged.
REQ-027 Load [[0,1,1,0],[1,0,2,2]], start -> FIX used for c=0; success=1; readback [[1,0,2,2],[0,1,1,0]].
REQ-028 Load [[1,2,0,1],[2,1,0,2]], start -> row1 becomes [0,0,0,0], fail=1, success=0, done single pulse.
REQ-029 wr_en to address 0 with data 0 while busy, and start pulsed while busy -> array and result unaffected.
REQ-030 Assert rst during ELIM -> next cycle busy=0, done/success/fail=0; new load and start completes correctly.
